// File: rtl/pwm_bank_pkg.sv
// Shared types and constants for the PWM LED bank.
package pwm_bank_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_OFF     = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_FULL    = 2'd3
  } mode_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Configuration bus of the PWM bank: prescale setting and duty write port.
interface pwm_bank_if #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
);
  localparam int unsigned CH_W = pwm_bank_pkg::idx_w(CHANNELS);

  logic [PRESCALE_W-1:0] prescale;
  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [WIDTH-1:0]      wr_duty;

  modport master (output prescale, output wr_en, output wr_ch, output wr_duty);
  modport slave  (input prescale, input wr_en, input wr_ch, input wr_duty);
endinterface

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse per debounced press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0]            sync_q;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  level_dly_q;
  logic                  press_q;

  // Any cycle where the synchronized input matches the level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (&cnt_q) level_d = sync_q[1];
      else        cnt_d   = cnt_q + DEBOUNCE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_dly_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM LED driver with prescaled timebase, shadowed duty registers,
// free-running tap divider and button-selected display modes.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned TAP_BASE   = 10,
  parameter int unsigned DEBOUNCE_W = 16,
  parameter bit          INVERT     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_bank_if.slave           cfg,
  input  logic                btn_i,
  output logic [CHANNELS-1:0] pwm_out_o,
  output logic [TAPS-1:0]     taps_o,
  output logic                btn_press_o,
  output mode_e               mode_o
);

  localparam int unsigned DIV_W = TAP_BASE + TAPS;

  logic [DIV_W-1:0]      div_q;
  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [WIDTH-1:0]      pwm_cnt_q;
  logic [WIDTH-1:0]      shadow_q [CHANNELS];
  logic [WIDTH-1:0]      shadow_d [CHANNELS];
  logic [WIDTH-1:0]      active_q [CHANNELS];
  logic [WIDTH-1:0]      active_d [CHANNELS];
  logic [WIDTH-1:0]      ramp_q, ramp_d;
  logic                  ramp_up_q, ramp_up_d;
  mode_e                 mode_q;
  logic [CHANNELS-1:0]   on_d, pwm_out_q;
  logic                  tick, wrap, btn_press;

  // >= rather than == so a prescale shrinking below the count ticks at once.
  assign tick = (pre_cnt_q >= cfg.prescale);
  assign wrap = tick && (&pwm_cnt_q);

  btn_debounce #(
    .DEBOUNCE_W(DEBOUNCE_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_i),
    .press_o(btn_press)
  );

  // A write landing in the wrap cycle is forwarded straight into the active copy.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = (cfg.wr_en && (int'(cfg.wr_ch) == i)) ? cfg.wr_duty : shadow_q[i];
      active_d[i] = wrap ? shadow_d[i] : active_q[i];
    end
  end

  always_comb begin
    ramp_d    = ramp_q;
    ramp_up_d = ramp_up_q;
    if (wrap) begin
      if (ramp_up_q) begin
        if (&ramp_q) begin
          ramp_up_d = 1'b0;
          ramp_d    = ramp_q - WIDTH'(1);
        end else begin
          ramp_d    = ramp_q + WIDTH'(1);
        end
      end else begin
        if (ramp_q == '0) begin
          ramp_up_d = 1'b1;
          ramp_d    = ramp_q + WIDTH'(1);
        end else begin
          ramp_d    = ramp_q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    on_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (mode_q)
        MODE_NORMAL:  on_d[i] = (active_q[i] > pwm_cnt_q);
        MODE_OFF:     on_d[i] = 1'b0;
        MODE_BREATHE: on_d[i] = (ramp_q > pwm_cnt_q);
        MODE_FULL:    on_d[i] = 1'b1;
        default:      on_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      ramp_q    <= '0;
      ramp_up_q <= 1'b1;
      mode_q    <= MODE_NORMAL;
      pwm_out_q <= {CHANNELS{INVERT}};
    end else begin
      div_q     <= div_q + DIV_W'(1);
      pre_cnt_q <= tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
      if (tick) pwm_cnt_q <= pwm_cnt_q + WIDTH'(1);
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      ramp_q    <= ramp_d;
      ramp_up_q <= ramp_up_d;
      if (btn_press) mode_q <= mode_e'(mode_q + 2'd1);
      pwm_out_q <= on_d ^ {CHANNELS{INVERT}};
    end
  end

  assign pwm_out_o   = pwm_out_q;
  assign taps_o      = div_q[DIV_W-1 -: TAPS];
  assign btn_press_o = btn_press;
  assign mode_o      = mode_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: reset, divider taps, duty/shadow timing, debounce,
// display modes and prescale shrink.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [2:0] pwm_out;
  logic [7:0] taps;
  logic       btn_press;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_bank_if #(.CHANNELS(3), .WIDTH(8), .PRESCALE_W(16)) cfg_if ();

  pwm_bank #(
    .CHANNELS  (3),
    .WIDTH     (8),
    .PRESCALE_W(16),
    .TAPS      (8),
    .TAP_BASE  (10),
    .DEBOUNCE_W(4),
    .INVERT    (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg_if),
    .btn_i      (btn),
    .pwm_out_o  (pwm_out),
    .taps_o     (taps),
    .btn_press_o(btn_press),
    .mode_o     (mode)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_duty(input logic [1:0] ch, input logic [7:0] d);
    cfg_if.wr_ch   = ch;
    cfg_if.wr_duty = d;
    cfg_if.wr_en   = 1'b1;
    @(negedge clk);
    cfg_if.wr_en   = 1'b0;
  endtask

  // Counts on-cycles (active-low outputs) over n cycles; optionally writes at sample wr_at.
  task automatic count_on(input int n, input int wr_at, input logic [1:0] ch,
                          input logic [7:0] d, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!pwm_out[0]) c0++;
      if (!pwm_out[1]) c1++;
      if (!pwm_out[2]) c2++;
      if (i == wr_at) begin
        cfg_if.wr_ch   = ch;
        cfg_if.wr_duty = d;
        cfg_if.wr_en   = 1'b1;
      end else begin
        cfg_if.wr_en   = 1'b0;
      end
    end
    cfg_if.wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input logic [7:0] v, input string tag);
    int n;
    logic found;
    n = 0;
    found = (dut.pwm_cnt_q == v);
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      found = (dut.pwm_cnt_q == v);
    end
    check_val(tag, 32'(found), 32'd1);
  endtask

  task automatic press(input bit bounce, output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    if (bounce) begin
      for (int k = 0; k < 10; k++) begin
        btn = k[0];
        repeat (10) begin
          @(negedge clk);
          if (btn_press) pulses++;
        end
      end
    end
    btn = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (btn_press) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    btn = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (btn_press) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, lat, pulses, n, ex;
    logic [7:0] cnt0;
    logic found;

    rst_n = 1'b0;
    btn = 1'b1;
    cfg_if.prescale = '0;
    cfg_if.wr_en = 1'b0;
    cfg_if.wr_ch = '0;
    cfg_if.wr_duty = '0;
    repeat (3) @(negedge clk);
    check_val("rst_pwm_out", 32'(pwm_out), 32'd7);
    check_val("rst_mode", 32'(mode), 32'd0);
    check_val("rst_taps", 32'(taps), 32'd0);
    check_val("rst_press", 32'(btn_press), 32'd0);
    rst_n = 1'b1;

    repeat (1100) @(negedge clk);
    check_val("taps_1100", 32'(taps), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_taps", 32'(taps), 32'd0);
    check_val("async_pwm_out", 32'(pwm_out), 32'd7);
    check_val("async_mode", 32'(mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (taps[0] == 1'b0 && n < 1100) begin @(negedge clk); n++; end
    check_val("tap0_rise", 32'(n), 32'd1024);
    n = 0;
    while (taps[0] == 1'b1 && n < 1100) begin @(negedge clk); n++; end
    check_val("tap0_fall", 32'(n), 32'd1024);

    write_duty(2'd0, 8'd64);
    write_duty(2'd1, 8'd0);
    write_duty(2'd2, 8'd255);
    repeat (600) @(negedge clk);
    count_on(256, -1, 2'd0, 8'd0, c0, c1, c2);
    check_val("duty_ch0", 32'(c0), 32'd64);
    check_val("duty_ch1", 32'(c1), 32'd0);
    check_val("duty_ch2", 32'(c2), 32'd255);

    cfg_if.prescale = 16'd3;
    repeat (2100) @(negedge clk);
    count_on(1024, -1, 2'd0, 8'd0, c0, c1, c2);
    check_val("pre3_ch0", 32'(c0), 32'd256);
    check_val("pre3_ch1", 32'(c1), 32'd0);
    check_val("pre3_ch2", 32'(c2), 32'd1020);
    cfg_if.prescale = 16'd0;

    wait_cnt(8'd0, "sync_shadow");
    count_on(256, 99, 2'd0, 8'd128, c0, c1, c2);
    check_val("shadow_midperiod", 32'(c0), 32'd64);
    count_on(256, 254, 2'd0, 8'd32, c0, c1, c2);
    check_val("shadow_applied", 32'(c0), 32'd128);
    count_on(256, -1, 2'd0, 8'd0, c0, c1, c2);
    check_val("wrap_forward", 32'(c0), 32'd32);
    check_val("wrap_forward_ch2", 32'(c2), 32'd255);

    press(1'b1, lat, pulses);
    check_val("debounce_latency", 32'(lat), 32'd19);
    check_val("debounce_pulses", 32'(pulses), 32'd1);
    check_val("mode_1", 32'(mode), 32'd1);
    count_on(256, -1, 2'd0, 8'd0, c0, c1, c2);
    check_val("mode_off_on", 32'(c0 + c1 + c2), 32'd0);

    // Fresh start with ticks frozen so the ramp begins from a known point.
    rst_n = 1'b0;
    cfg_if.prescale = 16'hffff;
    @(negedge clk);
    rst_n = 1'b1;
    press(1'b0, lat, pulses);
    check_val("press2_pulses", 32'(pulses), 32'd1);
    check_val("mode_after_reset_1", 32'(mode), 32'd1);
    press(1'b0, lat, pulses);
    check_val("mode_2", 32'(mode), 32'd2);

    cfg_if.prescale = 16'd0;
    wait_cnt(8'd0, "sync_ramp");
    for (int p = 0; p < 258; p++) begin
      count_on(256, -1, 2'd0, 8'd0, c0, c1, c2);
      ex = (p <= 255) ? p : 510 - p;
      if (p inside {0, 1, 2, 128, 255, 256, 257}) begin
        check_val($sformatf("ramp_p%0d", p), 32'(c0), 32'(ex));
        check_val($sformatf("ramp_ch2_p%0d", p), 32'(c2), 32'(ex));
      end
    end

    press(1'b0, lat, pulses);
    check_val("mode_3", 32'(mode), 32'd3);
    count_on(256, -1, 2'd0, 8'd0, c0, c1, c2);
    check_val("mode_full_ch1", 32'(c1), 32'd256);
    press(1'b0, lat, pulses);
    check_val("mode_wrap_0", 32'(mode), 32'd0);
    count_on(256, -1, 2'd0, 8'd0, c0, c1, c2);
    check_val("mode_normal_ch1", 32'(c1), 32'd0);

    cfg_if.prescale = 16'd1000;
    n = 0;
    found = (dut.pre_cnt_q == 16'd500);
    while (!found && n < 1200) begin
      @(negedge clk);
      n++;
      found = (dut.pre_cnt_q == 16'd500);
    end
    check_val("pre_cnt_500", 32'(found), 32'd1);
    cnt0 = dut.pwm_cnt_q;
    cfg_if.prescale = 16'd5;
    @(negedge clk);
    check_val("shrink_tick", 32'(dut.pwm_cnt_q), 32'(cnt0 + 8'd1));
    check_val("shrink_reload", 32'(dut.pre_cnt_q), 32'd0);
    repeat (5) @(negedge clk);
    check_val("shrink_hold", 32'(dut.pwm_cnt_q), 32'(cnt0 + 8'd1));
    @(negedge clk);
    check_val("shrink_period6", 32'(dut.pwm_cnt_q), 32'(cnt0 + 8'd2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM LED driver with a free-running tap divider and a debounced mode button. It sits directly under the board top level: it drives the RGB LED and the spare header pins, and takes the raw user button. It replaces hard-wired LED levels and fixed divider taps with per-channel programmable duty, a prescaled PWM timebase and button-selected display modes.

## Interface

Parameters:
- `CHANNELS`, 3: number of PWM outputs.
- `WIDTH`, 8: duty/PWM counter resolution in bits.
- `PRESCALE_W`, 16: width of the prescale input.
- `TAPS`, 8: number of divider tap outputs.
- `TAP_BASE`, 10: divider bit driving `taps[0]`; `taps[k]` = divider bit `TAP_BASE+k`.
- `DEBOUNCE_W`, 16: button must be stable for 2^`DEBOUNCE_W` cycles.
- `INVERT`, 1: 1 = `pwm_out` active-low, for common-anode LEDs.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `prescale` in `PRESCALE_W`: PWM tick every `prescale`+1 cycles. Sampled continuously.
- `wr_en` in 1: duty write strobe.
- `wr_ch` in clog2(`CHANNELS`), minimum 1: channel index. Out-of-range writes are ignored.
- `wr_duty` in `WIDTH`: duty value.
- `btn` in 1: raw button, active-low, asynchronous.
- `pwm_out` out `CHANNELS`: registered PWM outputs.
- `taps` out `TAPS`: divider taps.
- `btn_press` out 1: one-cycle pulse per debounced press.
- `mode` out 2: current display mode.

## Operation

- **Divider.** Free-running, `TAP_BASE+TAPS` bits wide, increments every cycle and wraps naturally. `taps` are direct register bits.
- **Prescaler.** `pre_cnt` counts 0..`prescale`. `tick` is asserted in the cycle `pre_cnt`==`prescale`, and `pre_cnt` returns to 0 that cycle. `prescale`=0 gives a tick every cycle. If `prescale` drops below `pre_cnt`, the next cycle is treated as a match: tick, then reload to 0. There is no runaway.
- **PWM counter.** `pwm_cnt` has `WIDTH` bits and advances on `tick`, wrapping 2^W−1→0. `wrap` = `tick` && `pwm_cnt`==2^W−1.
- **Duty registers.**
  - Writes go to a per-channel shadow register.
  - Every shadow is copied to the active register on `wrap`.
  - A write in the same cycle as `wrap` is forwarded, so the new value becomes active.
- **Compare.** Channel i is on when `active_duty[i]` > `pwm_cnt`.
  - Duty 0 is always off.
  - Duty 2^W−1 is on for 2^W−1 of 2^W counts.
- **Modes.** `mode` increments on `btn_press` and wraps 3→0.
  - 0 NORMAL: per-channel active duty.
  - 1 OFF: all channels off.
  - 2 BREATHE: every channel uses a shared triangle `ramp`. `ramp` steps ±1 on each `wrap`, reverses at 0 and 2^W−1, and resets to 0 going up.
  - 3 FULL: all channels always on.
- **Output polarity.** `pwm_out[i]` = on XOR `INVERT`.
- **Button path.**
  - Two-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input has differed from it for 2^`DEBOUNCE_W` consecutive cycles.
  - Any bounce restarts the count.
  - `btn_press` pulses on a debounced high→low transition only. Release produces no pulse.

## Timing

- Reset values:
  - all counters, shadow and active duties, and `ramp` are 0; `ramp` direction is up;
  - `mode`=0 and `btn_press`=0;
  - debounced level = 1 (released);
  - `taps`=0;
  - `pwm_out` = {CHANNELS{INVERT}}, i.e. all off.
- `pwm_out` is registered and lags `pwm_cnt`/`mode` by 1 cycle.
- A write reaches the output no earlier than the cycle after the next `wrap`.
- `btn_press` is high for exactly 1 cycle. It occurs 2 (sync) + 2^`DEBOUNCE_W` + 1 cycles after a clean press edge.
- A mode change takes effect on `pwm_out` 1 cycle after `btn_press`.
- Reset mid-period returns everything to the reset state immediately and asynchronously. Release is synchronous to `clk` in the usual way.

## Structure

- Package `pwm_bank_pkg` holds:
  - mode constants `MODE_NORMAL`=0, `MODE_OFF`=1, `MODE_BREATHE`=2, `MODE_FULL`=3;
  - the 2-bit mode type.
- Sub-module `btn_debounce` contains the synchronizer, debounce counter and press-pulse generator. It takes `DEBOUNCE_W` as a parameter.
- The rest stays flat in `pwm_bank`.

## Test plan

- **Reset and idle.** Hold `rst_n`=0 mid-run with `INVERT`=1. Expect `pwm_out`=3'b111, `mode`=0, `taps`=0. After release, `taps[0]` toggles every 1024 cycles.
- **Duty and prescale.** `WIDTH`=8, `prescale`=0; write ch0=64, ch1=0, ch2=255. After the next wrap, over a 256-cycle period ch0 is on 64 cycles, ch1 is on 0 cycles and ch2 is on 255 cycles. With `prescale`=3 the period is 1024 cycles.
- **Shadow timing.** Write ch0=128 mid-period: the current period is unchanged. Write ch0=32 exactly in the `wrap` cycle: the following period shows 32 on-counts.
- **Debounce.** `DEBOUNCE_W`=4. A press bouncing every 10 cycles for 100 cycles, then held, produces exactly one `btn_press`, 2+16+1 cycles after the last bounce. Release produces no pulse.
- **Modes.** Four presses step `mode` 0→1→2→3→0. In mode 2, `ramp` reaches 255 after 255 wraps, then decrements. Mode 3 gives `pwm_out` constantly on.
- **Prescale shrink.** `prescale` 1000→5 while `pre_cnt`=500. Expect a tick on the next cycle, then a tick every 6 cycles.
